// File: rtl/drs_seq_pkg.sv
// Shared state/command encoding for the DRS4 readout sequencer.
// The READ (5) and ACK (6) codes are the ones the DRS_READ engine decodes.
package drs_seq_pkg;

  localparam logic [3:0] COM_IDLE  = 4'd0;
  localparam logic [3:0] COM_ARMED = 4'd1;
  localparam logic [3:0] COM_STOP  = 4'd3;
  localparam logic [3:0] COM_READ  = 4'd5;
  localparam logic [3:0] COM_ACK   = 4'd6;
  localparam logic [3:0] COM_REARM = 4'd7;

  typedef enum logic [3:0] {
    S_IDLE  = COM_IDLE,
    S_ARMED = COM_ARMED,
    S_STOP  = COM_STOP,
    S_READ  = COM_READ,
    S_ACK   = COM_ACK,
    S_REARM = COM_REARM
  } state_t;

endpackage

// File: rtl/drs_seq_timer.sv
// Loadable down-counter that holds at zero; flags zero and "decrementing into zero".
module drs_seq_timer #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST)                    cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - {{(W-1){1'b0}}, 1'b1};
  end

  assign zero = (cnt == '0);
  assign one  = (cnt == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/drs_readout_sequencer.sv
// DRS4 trigger-to-readout sequencer driving DRS_STATE_COM for the DRS_READ engine.
// Define DRS_SEQ_VETO_CNT_EN to build the refused-trigger counter behind VETO_COUNT.
module drs_readout_sequencer
  import drs_seq_pkg::*;
#(
  parameter int TIMEOUT_W    = 16,
  parameter int REARM_CYCLES = 64,
  parameter int EVT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic             TRIG_IN,
  input  logic [7:0]       STOP_DELAY,
  input  logic             DFIFO_PROGFULL_IN,
  input  logic             DRS_READ_DONE_IN,
  output logic [3:0]       DRS_STATE_COM,
  output logic             DRS_DENABLE,
  output logic             DRS_DWRITE,
  output logic             BUSY,
  output logic             TRIG_ACCEPT,
  output logic [EVT_W-1:0] EVT_COUNT,
  output logic             READ_TIMEOUT_ERR,
  output logic [15:0]      VETO_COUNT
);

  localparam int TMR_W = ($clog2(REARM_CYCLES + 1) > 8) ? $clog2(REARM_CYCLES + 1) : 8;

  state_t           state;
  logic             accept;
  logic             tmr_load, tmr_zero, tmr_one;
  logic [TMR_W-1:0] tmr_val;
  logic             wd_load, wd_zero, wd_one;

  assign accept        = (state == S_ARMED) && TRIG_IN && !DFIFO_PROGFULL_IN;
  assign DRS_STATE_COM = state;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TMR_W'(REARM_CYCLES);
    wd_load  = 1'b0;
    case (state)
      S_IDLE:  tmr_load = ENABLE;
      S_ACK:   tmr_load = !DRS_READ_DONE_IN && ENABLE;
      S_ARMED: if (accept) begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(STOP_DELAY);
      end
      // Watchdog is armed on the same edge that enters READ.
      S_STOP:  wd_load = !DRS_DWRITE;
      default: ;
    endcase
  end

  drs_seq_timer #(.W(TMR_W)) u_tmr (
    .CLK(CLK), .RST(RST), .load(tmr_load), .load_val(tmr_val),
    .dec(state == S_REARM || state == S_STOP), .zero(tmr_zero), .one(tmr_one)
  );

  drs_seq_timer #(.W(TIMEOUT_W)) u_wd (
    .CLK(CLK), .RST(RST), .load(wd_load), .load_val('1),
    .dec(state == S_READ), .zero(wd_zero), .one(wd_one)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= S_IDLE;
      DRS_DENABLE      <= 1'b0;
      DRS_DWRITE       <= 1'b0;
      BUSY             <= 1'b0;
      TRIG_ACCEPT      <= 1'b0;
      EVT_COUNT        <= '0;
      READ_TIMEOUT_ERR <= 1'b0;
    end else begin
      TRIG_ACCEPT <= 1'b0;
      BUSY        <= 1'b1;
      case (state)
        S_IDLE: if (ENABLE) begin
          state       <= S_REARM;
          DRS_DENABLE <= 1'b1;
          DRS_DWRITE  <= 1'b1;
        end
        S_REARM: begin
          if (!ENABLE) begin
            state       <= S_IDLE;
            DRS_DENABLE <= 1'b0;
            DRS_DWRITE  <= 1'b0;
          end else if (tmr_one || tmr_zero) begin
            state <= S_ARMED;
            BUSY  <= 1'b0;
          end
        end
        S_ARMED: begin
          if (accept) begin
            state       <= S_STOP;
            TRIG_ACCEPT <= 1'b1;
            EVT_COUNT   <= EVT_COUNT + EVT_W'(1);
          end else if (!ENABLE) begin
            state       <= S_IDLE;
            DRS_DENABLE <= 1'b0;
            DRS_DWRITE  <= 1'b0;
          end else begin
            BUSY <= 1'b0;
          end
        end
        // Freeze first, hand off to the reader one cycle later.
        S_STOP: begin
          if (!DRS_DWRITE)   state      <= S_READ;
          else if (tmr_zero) DRS_DWRITE <= 1'b0;
        end
        S_READ: begin
          if (DRS_READ_DONE_IN) begin
            state <= S_ACK;
          end else if (wd_one || wd_zero) begin
            state            <= S_ACK;
            READ_TIMEOUT_ERR <= 1'b1;
          end
        end
        S_ACK: if (!DRS_READ_DONE_IN) begin
          if (ENABLE) begin
            state      <= S_REARM;
            DRS_DWRITE <= 1'b1;
          end else begin
            state       <= S_IDLE;
            DRS_DENABLE <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DRS_SEQ_VETO_CNT_EN
  logic [15:0] veto_q;
  logic        veto_hit;

  assign veto_hit = TRIG_IN && ((state == S_ARMED) ? DFIFO_PROGFULL_IN : ENABLE);

  always_ff @(posedge CLK) begin
    if (RST)                               veto_q <= '0;
    else if (veto_hit && veto_q != 16'hFFFF) veto_q <= veto_q + 16'd1;
  end

  assign VETO_COUNT = veto_q;
`else
  assign VETO_COUNT = '0;
`endif

endmodule

// File: tb/tb_drs_readout_sequencer.sv
// Directed bench: expected output events are queued by the driver, popped by a negedge monitor.
module tb_drs_readout_sequencer;

  logic        CLK = 1'b0;
  logic        RST, ENABLE, TRIG_IN, DFIFO_PROGFULL_IN, DRS_READ_DONE_IN;
  logic [7:0]  STOP_DELAY;
  logic [3:0]  DRS_STATE_COM;
  logic        DRS_DENABLE, DRS_DWRITE, BUSY, TRIG_ACCEPT, READ_TIMEOUT_ERR;
  logic [31:0] EVT_COUNT;
  logic [15:0] VETO_COUNT;

  drs_readout_sequencer #(.TIMEOUT_W(8), .REARM_CYCLES(64), .EVT_W(32)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .TRIG_IN(TRIG_IN), .STOP_DELAY(STOP_DELAY),
    .DFIFO_PROGFULL_IN(DFIFO_PROGFULL_IN), .DRS_READ_DONE_IN(DRS_READ_DONE_IN),
    .DRS_STATE_COM(DRS_STATE_COM), .DRS_DENABLE(DRS_DENABLE), .DRS_DWRITE(DRS_DWRITE),
    .BUSY(BUSY), .TRIG_ACCEPT(TRIG_ACCEPT), .EVT_COUNT(EVT_COUNT),
    .READ_TIMEOUT_ERR(READ_TIMEOUT_ERR), .VETO_COUNT(VETO_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  com;
    logic        dw, den, busy, acc, err;
    logic [31:0] evt;
  } ev_t;

  ev_t  exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 0;
  logic [3:0] prev_com = '0;
  logic       prev_dw = 1'b0;

`ifdef DRS_SEQ_VETO_CNT_EN
  localparam int VETO_ON = 1;
`else
  localparam int VETO_ON = 0;
`endif

  always @(posedge CLK) cyc <= cyc + 1;

  // An event is any COM change, an accept pulse or a DWRITE fall.
  always @(negedge CLK) begin
    ev_t a, e;
    if (mon_en && ((DRS_STATE_COM != prev_com) || TRIG_ACCEPT || (prev_dw && !DRS_DWRITE))) begin
      a = '{cyc: cyc, com: DRS_STATE_COM, dw: DRS_DWRITE, den: DRS_DENABLE, busy: BUSY,
            acc: TRIG_ACCEPT, err: READ_TIMEOUT_ERR, evt: EVT_COUNT};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: cyc=%0d com=%0d dw=%0b acc=%0b, none expected",
                 cyc, DRS_STATE_COM, DRS_DWRITE, TRIG_ACCEPT);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL event: got cyc=%0d com=%0d dw=%0b den=%0b busy=%0b acc=%0b err=%0b evt=%0d; want cyc=%0d com=%0d dw=%0b den=%0b busy=%0b acc=%0b err=%0b evt=%0d",
                   a.cyc, a.com, a.dw, a.den, a.busy, a.acc, a.err, a.evt,
                   e.cyc, e.com, e.dw, e.den, e.busy, e.acc, e.err, e.evt);
        end
      end
    end
    prev_com = DRS_STATE_COM;
    prev_dw  = DRS_DWRITE;
  end

  task automatic at(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  task automatic ex(input int c, input logic [3:0] com, input logic dw, den, busy, acc,
                    input int evt, input logic err);
    exp_q.push_back('{cyc: c, com: com, dw: dw, den: den, busy: busy, acc: acc, err: err, evt: evt});
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "bench stuck");
  end

  initial begin
    RST = 1'b1; ENABLE = 1'b0; TRIG_IN = 1'b0; STOP_DELAY = 8'd0;
    DFIFO_PROGFULL_IN = 1'b0; DRS_READ_DONE_IN = 1'b0;

    // Reset state
    at(3);
    chk("rst_com", 32'(DRS_STATE_COM), 0);
    chk("rst_dwrite", 32'(DRS_DWRITE), 0);
    chk("rst_denable", 32'(DRS_DENABLE), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_evt", EVT_COUNT, 0);
    chk("rst_err", 32'(READ_TIMEOUT_ERR), 0);
    chk("rst_veto", 32'(VETO_COUNT), 0);
    mon_en = 1;

    // Enable from reset: 64 cycles of REARM then ARMED
    RST = 1'b0; ENABLE = 1'b1;
    ex(4,  4'd7, 1, 1, 1, 0, 0, 0);
    ex(68, 4'd1, 1, 1, 0, 0, 0, 0);

    // Trigger with STOP_DELAY=10 while ENABLE drops the same cycle: trigger wins
    at(70);
    TRIG_IN = 1'b1; ENABLE = 1'b0; STOP_DELAY = 8'd10;
    ex(71, 4'd3, 1, 1, 1, 1, 1, 0);
    ex(82, 4'd3, 0, 1, 1, 0, 1, 0);
    ex(83, 4'd5, 0, 1, 1, 0, 1, 0);
    at(71);
    TRIG_IN = 1'b0; ENABLE = 1'b1;

    // DONE at READ+200, held 3 cycles, then re-arm
    at(282);
    DRS_READ_DONE_IN = 1'b1;
    ex(283, 4'd6, 0, 1, 1, 0, 1, 0);
    at(285);
    DRS_READ_DONE_IN = 1'b0;
    ex(286, 4'd7, 1, 1, 1, 0, 1, 0);
    ex(350, 4'd1, 1, 1, 0, 0, 1, 0);
    at(300); TRIG_IN = 1'b1;   // busy trigger during REARM
    at(301); TRIG_IN = 1'b0;

    // Prog-full: three refused triggers
    at(352);
    DFIFO_PROGFULL_IN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      at(353 + 2*i); TRIG_IN = 1'b1;
      at(354 + 2*i); TRIG_IN = 1'b0;
    end
    at(360);
    chk("pf_com", 32'(DRS_STATE_COM), 1);
    chk("pf_busy", 32'(BUSY), 0);
    chk("pf_evt", EVT_COUNT, 1);
    chk("pf_veto", 32'(VETO_COUNT), VETO_ON ? 4 : 0);
    DFIFO_PROGFULL_IN = 1'b0;

    // STOP_DELAY=0, reader never answers: watchdog after 255 cycles
    at(362);
    TRIG_IN = 1'b1; STOP_DELAY = 8'd0;
    ex(363, 4'd3, 1, 1, 1, 1, 2, 0);
    ex(364, 4'd3, 0, 1, 1, 0, 2, 0);
    ex(365, 4'd5, 0, 1, 1, 0, 2, 0);
    ex(620, 4'd6, 0, 1, 1, 0, 2, 1);
    ex(621, 4'd7, 1, 1, 1, 0, 2, 1);
    ex(685, 4'd1, 1, 1, 0, 0, 2, 1);
    at(363);
    TRIG_IN = 1'b0;

    // Reset mid-STOP with a trigger present
    at(690);
    TRIG_IN = 1'b1; STOP_DELAY = 8'd20;
    ex(691, 4'd3, 1, 1, 1, 1, 3, 1);
    at(691);
    TRIG_IN = 1'b0;
    at(695);
    RST = 1'b1; TRIG_IN = 1'b1;
    ex(696, 4'd0, 0, 0, 0, 0, 0, 0);
    at(696);
    RST = 1'b0; TRIG_IN = 1'b0; ENABLE = 1'b0;
    chk("rst2_veto", 32'(VETO_COUNT), 0);
    at(698);
    chk("idle_busy", 32'(BUSY), 1);
    chk("idle_com", 32'(DRS_STATE_COM), 0);

    // ENABLE dropped during REARM returns to IDLE; idle trigger not counted
    at(700);
    ENABLE = 1'b1;
    ex(701, 4'd7, 1, 1, 1, 0, 0, 0);
    at(710);
    ENABLE = 1'b0;
    ex(711, 4'd0, 0, 0, 1, 0, 0, 0);
    at(712); TRIG_IN = 1'b1;
    at(713); TRIG_IN = 1'b0;
    at(716);
    chk("idle_trig_evt", EVT_COUNT, 0);
    chk("idle_trig_veto", 32'(VETO_COUNT), 0);
    chk("events_pending", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
